// File: rtl/l1_insn_cache_assoc.sv
// l1_insn_cache_assoc
// Blocking set-associative L1 instruction cache sitting between the fetch
// stage and the memory bus. Lines are one word wide. Hits are answered from
// local tag/data arrays; a miss is forwarded to memory, the returned word is
// written into one way of the indexed set and then handed to the CPU.
// At most one request is in flight at any time.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cpu_req_*           fetch request (valid/ready, byte address, source ID)
//   cpu_rsp_*           fetch response (valid/ready, data, address, source ID)
//   mem_req_*           miss request to memory (valid/ready, address, source ID)
//   mem_rsp_*           fill from memory (valid/ready, data, address)
//   flush               pulse: invalidate every line
//   busy                high whenever the cache is not idle (including INIT)
//   stat_hits/misses    lookup hit/miss counters, only present when
//                       L1_INSN_CACHE_STATS_EN is defined
//
// Every output is 0 in reset except busy, which reports the INIT state the
// cache resets into.
module l1_insn_cache_assoc #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int SRC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [SRC_W-1:0]  cpu_req_src,
  output logic              cpu_rsp_valid,
  input  logic              cpu_rsp_ready,
  output logic [DATA_W-1:0] cpu_rsp_data,
  output logic [ADDR_W-1:0] cpu_rsp_addr,
  output logic [SRC_W-1:0]  cpu_rsp_src,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [SRC_W-1:0]  mem_req_src,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic [ADDR_W-1:0] mem_rsp_addr,
  input  logic              flush,
  output logic              busy
`ifdef L1_INSN_CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_RESP
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] req_addr;
  logic [SRC_W-1:0]  req_src;
  logic [IDX_W-1:0]  init_idx;
  logic              flush_pend;

  logic [WAYS-1:0]   valid_mem [SETS];
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [DATA_W-1:0] data_mem  [SETS][WAYS];
  logic [WAY_W-1:0]  rr_ptr    [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WAYS-1:0]   hit_vec;
  logic [DATA_W-1:0] hit_data;
  logic [WAY_W-1:0]  victim;
  logic              victim_rr;
  logic              flush_take;
  logic              fill;

  assign req_idx    = req_addr[OFF +: IDX_W];
  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign flush_take = flush || flush_pend;
  assign fill       = (state == S_MISS_WAIT) && mem_rsp_valid;

  // A flush (live or remembered) blocks acceptance so it always wins in IDLE.
  assign cpu_req_ready = (state == S_IDLE) && !flush_take;
  assign cpu_rsp_valid = (state == S_RESP);
  assign mem_req_valid = (state == S_MISS_REQ);
  assign mem_rsp_ready = (state == S_MISS_WAIT);
  assign mem_req_addr  = req_addr;
  assign mem_req_src   = req_src;
  assign busy          = (state != S_IDLE);

  always_comb begin
    hit_vec  = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit_vec[w] = 1'b1;
        hit_data   = data_mem[req_idx][w];
      end
    end
  end

  // Scanning downwards lets the lowest-numbered invalid way win; the
  // round-robin pointer is only the fallback when the set is full.
  always_comb begin
    victim    = rr_ptr[req_idx];
    victim_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[req_idx][w]) begin
        victim    = WAY_W'(w);
        victim_rr = 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:      if (init_idx == IDX_W'(SETS - 1)) state_nxt = S_IDLE;
      S_IDLE:      if (flush_take) state_nxt = S_INIT;
                   else if (cpu_req_valid) state_nxt = S_LOOKUP;
      S_LOOKUP:    state_nxt = (|hit_vec) ? S_RESP : S_MISS_REQ;
      S_MISS_REQ:  if (mem_req_ready) state_nxt = S_MISS_WAIT;
      S_MISS_WAIT: if (mem_rsp_valid) state_nxt = S_RESP;
      S_RESP:      if (cpu_rsp_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_INIT;
    endcase
  end

  // init_idx wraps back to 0 on the last INIT cycle, ready for the next flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      req_addr     <= '0;
      req_src      <= '0;
      init_idx     <= '0;
      flush_pend   <= 1'b0;
      cpu_rsp_data <= '0;
      cpu_rsp_addr <= '0;
      cpu_rsp_src  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) init_idx <= init_idx + 1'b1;
      if (state == S_IDLE) flush_pend <= 1'b0;
      else if (flush) flush_pend <= 1'b1;
      if (cpu_req_valid && cpu_req_ready) begin
        req_addr <= cpu_req_addr;
        req_src  <= cpu_req_src;
      end
      if ((state == S_LOOKUP) && (|hit_vec)) begin
        cpu_rsp_data <= hit_data;
        cpu_rsp_addr <= req_addr;
        cpu_rsp_src  <= req_src;
      end else if (fill) begin
        cpu_rsp_data <= mem_rsp_data;
        cpu_rsp_addr <= req_addr;
        cpu_rsp_src  <= req_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        rr_ptr[s]    <= '0;
      end
    end else begin
      if (state == S_INIT) valid_mem[init_idx] <= '0;
      if (fill) begin
        valid_mem[req_idx][victim] <= 1'b1;
        if (victim_rr)
          rr_ptr[req_idx] <= (rr_ptr[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[req_idx] + 1'b1;
      end
    end
  end

  // The tag comes from the fill address, so a mismatching fill still lands
  // under the address memory actually returned.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[req_idx][victim]  <= mem_rsp_addr[ADDR_W-1 -: TAG_W];
      data_mem[req_idx][victim] <= mem_rsp_data;
    end
  end

`ifdef L1_INSN_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == S_LOOKUP) begin
      if (|hit_vec) begin
        if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 1'b1;
      end else begin
        if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 1'b1;
      end
    end
  end
`endif

  generate
    if (OFF > 0) begin : g_align_chk
      a_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        (cpu_req_valid && cpu_req_ready) |-> (cpu_req_addr[OFF-1:0] == '0));
    end
  endgenerate

  a_one_hit: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_LOOKUP) |-> $onehot0(hit_vec));

  a_fill_addr: assert property (@(posedge clk) disable iff (!rst_n)
    fill |-> (mem_rsp_addr == req_addr));

endmodule

// File: tb/tb_l1_insn_cache_assoc.sv
// Self-checking bench for l1_insn_cache_assoc (default parameters).
// A behavioural cache model (per-set arrays, first-invalid/round-robin
// victim choice) predicts hit/miss and data; a memory image supplies fills.
module tb_l1_insn_cache_assoc;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int SETS   = 64;
  localparam int WAYS   = 2;
  localparam int SRC_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req_valid, cpu_req_ready;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [SRC_W-1:0]  cpu_req_src;
  logic              cpu_rsp_valid, cpu_rsp_ready;
  logic [DATA_W-1:0] cpu_rsp_data;
  logic [ADDR_W-1:0] cpu_rsp_addr;
  logic [SRC_W-1:0]  cpu_rsp_src;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [SRC_W-1:0]  mem_req_src;
  logic              mem_rsp_valid, mem_rsp_ready;
  logic [DATA_W-1:0] mem_rsp_data;
  logic [ADDR_W-1:0] mem_rsp_addr;
  logic              flush, busy;
`ifdef L1_INSN_CACHE_STATS_EN
  logic [31:0]       stat_hits, stat_misses;
`endif

  l1_insn_cache_assoc #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS), .SRC_W(SRC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_src(cpu_req_src),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready),
    .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_addr(cpu_rsp_addr), .cpu_rsp_src(cpu_rsp_src),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_src(mem_req_src),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_addr(mem_rsp_addr),
    .flush(flush), .busy(busy)
`ifdef L1_INSN_CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          model_valid [SETS][WAYS];
  logic [63:0] model_tag   [SETS][WAYS];
  logic [63:0] model_data  [SETS][WAYS];
  int          model_rr    [SETS];
  int          model_hits, model_misses;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", name, observed, expected);
    end
  endtask

  function automatic logic [63:0] memWord(input logic [63:0] a);
    if (a == 64'h100) return 64'hDEAD;
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  function automatic int setOf(input logic [63:0] a);
    return int'((a >> 3) % SETS);
  endfunction

  function automatic logic [63:0] tagOf(input logic [63:0] a);
    return a >> 9;
  endfunction

  function automatic bit modelLookup(input logic [63:0] a, output logic [63:0] d);
    int s = setOf(a);
    d = '0;
    for (int w = 0; w < WAYS; w++)
      if (model_valid[s][w] && model_tag[s][w] == tagOf(a)) begin
        d = model_data[s][w];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic void modelFill(input logic [63:0] a, input logic [63:0] d);
    int s = setOf(a);
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (!model_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = model_rr[s];
      model_rr[s] = (model_rr[s] + 1) % WAYS;
    end
    model_valid[s][v] = 1'b1;
    model_tag[s][v]   = tagOf(a);
    model_data[s][v]  = d;
  endfunction

  function automatic void modelFlush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) model_valid[s][w] = 1'b0;
  endfunction

  function automatic void modelReset();
    modelFlush();
    for (int s = 0; s < SETS; s++) model_rr[s] = 0;
    model_hits = 0;
    model_misses = 0;
  endfunction

  task automatic waitInit();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("init_cycles", 64'(n), 64'(SETS));
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_req_ready", cpu_req_ready, 0);
    checkOutput("rst_rsp_valid", cpu_rsp_valid, 0);
    checkOutput("rst_rsp_data", cpu_rsp_data, 0);
    checkOutput("rst_rsp_addr", cpu_rsp_addr, 0);
    checkOutput("rst_rsp_src", cpu_rsp_src, 0);
    checkOutput("rst_mem_req_valid", mem_req_valid, 0);
    checkOutput("rst_mem_req_addr", mem_req_addr, 0);
    checkOutput("rst_mem_req_src", mem_req_src, 0);
    checkOutput("rst_mem_rsp_ready", mem_rsp_ready, 0);
    checkOutput("rst_busy_init", busy, 1);
`ifdef L1_INSN_CACHE_STATS_EN
    checkOutput("rst_stat_hits", stat_hits, 0);
    checkOutput("rst_stat_misses", stat_misses, 0);
`endif
  endtask

  task automatic checkStats();
`ifdef L1_INSN_CACHE_STATS_EN
    checkOutput("stat_hits", stat_hits, 64'(model_hits));
    checkOutput("stat_misses", stat_misses, 64'(model_misses));
`endif
  endtask

  // One full fetch transaction; entered and left at a negedge.
  task automatic applyStimulus(input logic [63:0] a, input logic [3:0] s,
                               input int memStall, input int rspStall, input bit flushInResp);
    logic [63:0] expData;
    bit expHit;
    int n;
    expHit = modelLookup(a, expData);
    if (expHit) model_hits++; else model_misses++;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    cpu_req_src   = s;
    n = 0;
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready", cpu_req_ready, 1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    checkOutput("lookup_rsp_valid", cpu_rsp_valid, 0);
    @(negedge clk);
    if (expHit) begin
      checkOutput("hit_no_mem_req", mem_req_valid, 0);
    end else begin
      checkOutput("miss_req_valid", mem_req_valid, 1);
      checkOutput("miss_req_addr", mem_req_addr, a);
      checkOutput("miss_req_src", mem_req_src, s);
      for (int i = 0; i < memStall; i++) begin
        @(negedge clk);
        checkOutput("req_hold_valid", mem_req_valid, 1);
        checkOutput("req_hold_addr", mem_req_addr, a);
        checkOutput("req_hold_src", mem_req_src, s);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      checkOutput("wait_rsp_ready", mem_rsp_ready, 1);
      checkOutput("wait_req_low", mem_req_valid, 0);
      expData = memWord(a);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = expData;
      mem_rsp_addr  = a;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      modelFill(a, expData);
    end
    checkOutput("rsp_valid", cpu_rsp_valid, 1);
    checkOutput("rsp_data", cpu_rsp_data, expData);
    checkOutput("rsp_addr", cpu_rsp_addr, a);
    checkOutput("rsp_src", cpu_rsp_src, s);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a + 64'h8;
    cpu_req_src   = ~s;
    for (int i = 0; i < rspStall; i++) begin
      flush = flushInResp && (i == 0);
      @(negedge clk);
      flush = 1'b0;
      checkOutput("stall_rsp_valid", cpu_rsp_valid, 1);
      checkOutput("stall_rsp_data", cpu_rsp_data, expData);
      checkOutput("stall_rsp_addr", cpu_rsp_addr, a);
      checkOutput("stall_req_blocked", cpu_req_ready, 0);
    end
    cpu_rsp_ready = 1'b1;
    @(negedge clk);
    cpu_rsp_ready = 1'b0;
    cpu_req_valid = 1'b0;
    checkOutput("rsp_drop", cpu_rsp_valid, 0);
    checkOutput("back_idle", busy, 0);
    if (flushInResp) begin
      checkOutput("pend_flush_blocks", cpu_req_ready, 0);
      modelFlush();
      @(negedge clk);
      waitInit();
    end
  endtask

  initial begin
    logic [63:0] a;
    int n;
    rst_n = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_src = '0;
    cpu_rsp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_addr = '0;
    flush = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;
    waitInit();

    // Directed: miss/fill then hit, with stalls on both handshakes.
    applyStimulus(64'h100, 4'h3, 3, 0, 1'b0);
    applyStimulus(64'h100, 4'h5, 0, 5, 1'b0);
    // Same-set eviction: 0x400 replaces 0x000, then 0x200 hits and 0x000 misses.
    applyStimulus(64'h000, 4'h1, 0, 0, 1'b0);
    applyStimulus(64'h200, 4'h2, 1, 0, 1'b0);
    applyStimulus(64'h400, 4'h4, 0, 1, 1'b0);
    applyStimulus(64'h200, 4'h6, 0, 0, 1'b0);
    applyStimulus(64'h000, 4'h7, 2, 0, 1'b0);
    checkStats();

    // Flush together with a request in IDLE: flush wins.
    applyStimulus(64'h100, 4'h8, 0, 0, 1'b0);
    flush = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_addr = 64'h100;
    #1;
    checkOutput("flush_blocks_req", cpu_req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    cpu_req_valid = 1'b0;
    modelFlush();
    waitInit();
    applyStimulus(64'h100, 4'h9, 0, 0, 1'b0);

    // Flush pulsed while a response is stalled is taken on return to IDLE.
    applyStimulus(64'h100, 4'hA, 0, 2, 1'b1);
    applyStimulus(64'h100, 4'hB, 0, 0, 1'b0);
    checkStats();

    // Randomized traffic over a small address pool to mix hits and misses.
    for (int i = 0; i < 40; i++) begin
      a = 64'(($urandom_range(0, 5) * SETS + $urandom_range(0, 2)) * 8);
      applyStimulus(a, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    checkStats();

    // Reset while waiting for a fill.
    cpu_req_valid = 1'b1;
    cpu_req_addr = 64'h1234_0000;
    cpu_req_src = 4'hC;
    n = 0;
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    checkOutput("pre_reset_wait", mem_rsp_ready, 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    waitInit();
    applyStimulus(64'h100, 4'hD, 0, 0, 1'b0);
    applyStimulus(64'h100, 4'hE, 0, 0, 1'b0);
    checkStats();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
